// File: rtl/serial_route_pkg.sv
// Shared definitions for the serial line router: output mode encoding and a
// width helper used for select and counter sizing.
package serial_route_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_IDLE  = 2'b01,
    MODE_BREAK = 2'b10,
    MODE_INV   = 2'b11
  } mode_t;

  // Bits needed to encode values 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/line_conditioner.sv
// One serial input: synchroniser, majority-free deglitch filter, break
// counter and sticky activity flag.
module line_conditioner
  import serial_route_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 3,
  parameter int BREAK_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  input  logic i_act_clr,
  output logic o_f,
  output logic o_break_det,
  output logic o_activity
);

  localparam int unsigned     CNTW    = clog2_min1(BREAK_CYCLES + 1);
  localparam logic [CNTW-1:0] BRK_MAX = CNTW'(BREAK_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic [FILTER_LEN-1:0]  w_window;
  logic                   w_f_next;
  logic                   r_f;
  logic [CNTW-1:0]        r_cnt;
  logic                   r_break;
  logic                   r_act;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // The filter window is the newest synchronised sample plus FILTER_LEN-1
  // older ones, so f can move on the same edge the last agreeing sample lands.
  generate
    if (FILTER_LEN == 1) begin : g_no_hist
      assign w_window = w_sync;
    end else begin : g_hist
      logic [FILTER_LEN-2:0] r_hist;
      always_ff @(posedge clk) begin
        if (rst) r_hist <= '1;
        else     r_hist <= w_window[FILTER_LEN-2:0];
      end
      assign w_window = {r_hist, w_sync};
    end
  endgenerate

  always_comb begin
    w_f_next = r_f;
    if (&w_window)       w_f_next = 1'b1;
    else if (~|w_window) w_f_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f     <= 1'b1;
      r_cnt   <= '0;
      r_break <= 1'b0;
      r_act   <= 1'b0;
    end else begin
      r_f <= w_f_next;
      if (r_f)                    r_cnt <= '0;
      else if (r_cnt != BRK_MAX)  r_cnt <= r_cnt + 1'b1;
      // Gating with the current level lets the flag drop one cycle after f rises.
      r_break <= !r_f && (r_cnt == BRK_MAX);
      if (w_f_next != r_f) r_act <= 1'b1;
      else if (i_act_clr)  r_act <= 1'b0;
    end
  end

  assign o_f         = r_f;
  assign o_break_det = r_break;
  assign o_activity  = r_act;

endmodule

// File: rtl/serial_line_router.sv
// Configurable crossbar of conditioned serial inputs onto registered outputs,
// each output with its own source select and drive mode.
module serial_line_router
  import serial_route_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 3,
  parameter int BREAK_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS-1:0]                  line_in,
  output logic [CHANNELS-1:0]                  line_out,
  input  logic                                 cfg_we,
  input  logic [clog2_min1(CHANNELS)-1:0]      cfg_ch,
  input  logic [clog2_min1(CHANNELS)-1:0]      cfg_src,
  input  logic [1:0]                           cfg_mode,
  output logic                                 cfg_err,
  output logic [CHANNELS-1:0]                  break_det,
  output logic [CHANNELS-1:0]                  activity,
  input  logic [CHANNELS-1:0]                  act_clr
);

  localparam int unsigned   CW       = clog2_min1(CHANNELS);
  localparam logic [CW:0]   CH_LIMIT = (CW + 1)'(CHANNELS);

  logic [CHANNELS-1:0] w_f;
  logic                w_cfg_ok;
  logic                r_cfg_err;

  // Both indices must be in range; non-power-of-two channel counts leave holes.
  assign w_cfg_ok = ({1'b0, cfg_ch} < CH_LIMIT) && ({1'b0, cfg_src} < CH_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) r_cfg_err <= 1'b0;
    else     r_cfg_err <= cfg_we && !w_cfg_ok;
  end

  assign cfg_err = r_cfg_err;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_in
      line_conditioner #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_LEN   (FILTER_LEN),
        .BREAK_CYCLES (BREAK_CYCLES)
      ) u_cond (
        .clk         (clk),
        .rst         (rst),
        .i_line      (line_in[gi]),
        .i_act_clr   (act_clr[gi]),
        .o_f         (w_f[gi]),
        .o_break_det (break_det[gi]),
        .o_activity  (activity[gi])
      );
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_out
      logic [CW-1:0] r_src;
      mode_t         r_mode;
      logic          r_out;
      logic          w_sel;
      logic          w_hit;

      assign w_sel = w_f[r_src];
      assign w_hit = cfg_we && w_cfg_ok && (cfg_ch == CW'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_src  <= CW'(gi);
          r_mode <= MODE_PASS;
          r_out  <= 1'b1;
        end else begin
          if (w_hit) begin
            r_src  <= cfg_src;
            r_mode <= mode_t'(cfg_mode);
          end
          case (r_mode)
            MODE_PASS:  r_out <= w_sel;
            MODE_IDLE:  r_out <= 1'b1;
            MODE_BREAK: r_out <= 1'b0;
            default:    r_out <= ~w_sel;
          endcase
        end
      end

      assign line_out[gi] = r_out;
    end
  endgenerate

endmodule

// File: tb/tb_serial_line_router.sv
// Scoreboard bench for serial_line_router: stimulus queues cycle-stamped
// expectations, a negedge monitor compares them when they fall due.
module tb_serial_line_router;
  import serial_route_pkg::*;

  localparam int CH      = 3;
  localparam int SIG_OUT = 0;
  localparam int SIG_BRK = 1;
  localparam int SIG_ACT = 2;
  localparam int SIG_ERR = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] line_in;
  logic [CH-1:0] line_out;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_src;
  logic [1:0]    cfg_mode;
  logic          cfg_err;
  logic [CH-1:0] break_det;
  logic [CH-1:0] activity;
  logic [CH-1:0] act_clr;

  serial_line_router #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (2),
    .FILTER_LEN   (3),
    .BREAK_CYCLES (1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line_in   (line_in),
    .line_out  (line_out),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_src   (cfg_src),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .break_det (break_det),
    .activity  (activity),
    .act_clr   (act_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   due;
    int            sig;
    logic [CH-1:0] exp;
    string         name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_lost = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int unsigned dly, input int sig,
                           input logic [CH-1:0] val, input string name);
    exp_t e;
    e.due  = cyc + dly;
    e.sig  = sig;
    e.exp  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] src, input logic [1:0] mode);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_src  = src;
    cfg_mode = mode;
    step(1);
    cfg_we   = 1'b0;
  endtask

  function automatic logic [CH-1:0] observe(input int sig);
    case (sig)
      SIG_OUT: return line_out;
      SIG_BRK: return break_det;
      SIG_ACT: return activity;
      default: return {{(CH-1){1'b0}}, cfg_err};
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    logic [CH-1:0] got;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        got = observe(sb[i].sig);
        n_checks++;
        if (sb[i].due != cyc)
          $display("FAIL %s: not sampled at cycle %0d (seen at %0d), required %b",
                   sb[i].name, sb[i].due, cyc, sb[i].exp);
        else if (got !== sb[i].exp)
          $display("FAIL %s: cycle %0d got %b required %b", sb[i].name, cyc, got, sb[i].exp);
        else begin
          n_pass++;
          $display("ok   %s: cycle %0d value %b", sb[i].name, cyc, got);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    line_in  = '1;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_src  = '0;
    cfg_mode = '0;
    act_clr  = '0;
    step(3);
    rst = 1'b0;
    expect_at(0, SIG_OUT, 3'b111, "reset_line_out");
    expect_at(0, SIG_BRK, 3'b000, "reset_break");
    expect_at(0, SIG_ACT, 3'b000, "reset_activity");
    expect_at(0, SIG_ERR, 3'b000, "reset_cfg_err");
    step(2);

    // Input 0 low: five-cycle path, other outputs untouched.
    line_in = 3'b110;
    expect_at(4, SIG_OUT, 3'b111, "latency_before");
    expect_at(6, SIG_OUT, 3'b110, "latency_pass");
    expect_at(6, SIG_ACT, 3'b001, "activity_set");
    step(8);
    line_in = 3'b111;
    expect_at(6, SIG_OUT, 3'b111, "pass_return_high");
    step(8);

    // Output 1 inverts input 0.
    expect_at(1, SIG_OUT, 3'b111, "inv_before");
    expect_at(1, SIG_ERR, 3'b000, "valid_write_no_err");
    expect_at(2, SIG_OUT, 3'b101, "inv_after");
    cfg_write(2'd1, 2'd0, MODE_INV);
    step(3);
    line_in = 3'b110;
    expect_at(4, SIG_OUT, 3'b101, "inv_toggle_before");
    expect_at(6, SIG_OUT, 3'b110, "inv_toggle_low");
    step(8);
    line_in = 3'b111;
    expect_at(6, SIG_OUT, 3'b101, "inv_toggle_high");
    step(8);

    // Output 2 follows input 1 so its filter is visible on a pin.
    expect_at(2, SIG_OUT, 3'b101, "route_2_from_1");
    cfg_write(2'd2, 2'd1, MODE_PASS);
    step(2);

    // Two-cycle glitch is swallowed.
    line_in = 3'b101;
    expect_at(5, SIG_OUT, 3'b101, "glitch_mid");
    expect_at(8, SIG_OUT, 3'b101, "glitch_out");
    expect_at(8, SIG_ACT, 3'b001, "glitch_activity");
    expect_at(8, SIG_BRK, 3'b000, "glitch_break");
    step(2);
    line_in = 3'b111;
    step(8);

    // Three-cycle pulse is just long enough to pass.
    line_in = 3'b101;
    expect_at(7, SIG_OUT, 3'b001, "pulse3_low");
    expect_at(10, SIG_OUT, 3'b101, "pulse3_high");
    expect_at(10, SIG_ACT, 3'b011, "pulse3_activity");
    step(3);
    line_in = 3'b111;
    step(9);

    act_clr = 3'b011;
    expect_at(1, SIG_ACT, 3'b000, "act_clr");
    step(1);
    act_clr = '0;
    step(2);

    // Clear coincides with an accepted edge, then a long low for break.
    line_in = 3'b110;
    expect_at(4, SIG_ACT, 3'b000, "collide_before");
    expect_at(5, SIG_ACT, 3'b001, "collide_set_wins");
    expect_at(6, SIG_ACT, 3'b001, "collide_hold");
    expect_at(6, SIG_OUT, 3'b110, "break_line_out");
    expect_at(1029, SIG_BRK, 3'b000, "break_before");
    expect_at(1030, SIG_BRK, 3'b001, "break_rise");
    expect_at(1099, SIG_BRK, 3'b001, "break_saturated");
    step(4);
    act_clr = 3'b001;
    step(1);
    act_clr = '0;
    step(1095);
    line_in = 3'b111;
    expect_at(5, SIG_BRK, 3'b001, "break_hold_until_f");
    expect_at(6, SIG_BRK, 3'b000, "break_fall");
    expect_at(6, SIG_OUT, 3'b101, "break_release_out");
    step(8);

    // Rejected writes: bad source, then bad channel.
    expect_at(1, SIG_ERR, 3'b001, "err_src_pulse");
    expect_at(2, SIG_ERR, 3'b000, "err_src_single");
    expect_at(3, SIG_OUT, 3'b101, "err_src_route");
    cfg_write(2'd0, 2'd3, MODE_BREAK);
    step(3);
    expect_at(1, SIG_ERR, 3'b001, "err_ch_pulse");
    expect_at(2, SIG_ERR, 3'b000, "err_ch_single");
    expect_at(3, SIG_OUT, 3'b101, "err_ch_route");
    cfg_write(2'd3, 2'd0, MODE_BREAK);
    step(3);

    // Forced break on output 0, input 1 held into break, then reset.
    expect_at(2, SIG_OUT, 3'b100, "mode_break");
    cfg_write(2'd0, 2'd0, MODE_BREAK);
    step(2);
    line_in = 3'b101;
    expect_at(6, SIG_OUT, 3'b000, "pre_rst_out");
    expect_at(6, SIG_ACT, 3'b011, "pre_rst_act");
    expect_at(1030, SIG_BRK, 3'b010, "pre_rst_break");
    step(1040);
    rst      = 1'b1;
    cfg_we   = 1'b1;
    cfg_ch   = 2'd1;
    cfg_src  = 2'd2;
    cfg_mode = MODE_IDLE;
    act_clr  = 3'b111;
    expect_at(1, SIG_OUT, 3'b111, "rst_line_out");
    expect_at(1, SIG_BRK, 3'b000, "rst_break");
    expect_at(1, SIG_ACT, 3'b000, "rst_activity");
    expect_at(1, SIG_ERR, 3'b000, "rst_cfg_err");
    expect_at(6, SIG_OUT, 3'b111, "post_rst_hold");
    expect_at(7, SIG_OUT, 3'b101, "identity_restored");
    expect_at(7, SIG_ACT, 3'b010, "post_rst_act");
    expect_at(1030, SIG_BRK, 3'b000, "post_rst_cnt_zero");
    expect_at(1031, SIG_BRK, 3'b010, "post_rst_break");
    step(1);
    rst     = 1'b0;
    cfg_we  = 1'b0;
    act_clr = '0;
    step(1040);

    for (int k = 0; k < 50 && sb.size() != 0; k++) step(1);
    if (sb.size() != 0) begin
      n_lost = sb.size();
      $display("FAIL drain: %0d expectations still pending, required 0", n_lost);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks + n_lost);
    $finish;
  end

endmodule

// File: doc/serial_line_router.md
# serial_line_router

Parametrised, registered routing block for low-speed serial lines (UART RxD/TxD and similar) between board connectors and the CPU's serial peripherals. Each of `CHANNELS` inputs is synchronised, deglitched and watched for break/activity. Each output drives a runtime-selected input with a per-output mode (pass, forced idle, forced break, inverted). It replaces fixed pin-to-pin wiring with a configurable, metastability-safe crossbar.

## Interface
Parameters:
- `CHANNELS`, 2: number of input lines and number of output lines (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per input (≥2).
- `FILTER_LEN`, 3: consecutive equal samples required to accept a level change (≥1).
- `BREAK_CYCLES`, 1024: consecutive filtered-low cycles that flag a break (≥1).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous active-high reset.
- `line_in`, in, CHANNELS: asynchronous serial inputs; idle level 1.
- `line_out`, out, CHANNELS: registered serial outputs.
- `cfg_we`, in, 1: single-cycle configuration write strobe.
- `cfg_ch`, in, CW: output channel being configured. CW = max(1, clog2(CHANNELS)).
- `cfg_src`, in, CW: input index routed to `cfg_ch`.
- `cfg_mode`, in, 2: mode for `cfg_ch`.
- `cfg_err`, out, 1: one-cycle pulse when a write is rejected.
- `break_det`, out, CHANNELS: per input, high while a break condition holds.
- `activity`, out, CHANNELS: per input, sticky flag set on any accepted edge.
- `act_clr`, in, CHANNELS: per input, clears `activity`.

## Operation
- Input path, per channel:
  - `SYNC_STAGES` flop synchroniser feeds a `FILTER_LEN`-deep sample shift register.
  - The filtered level `f[i]` changes only when all `FILTER_LEN` samples agree and differ from the current `f[i]`; otherwise `f[i]` holds.
  - Synchronised pulses shorter than `FILTER_LEN` cycles never reach `f[i]`.
- Break detector, per input:
  - Counter of width clog2(BREAK_CYCLES+1).
  - Increments while `f[i]`=0 and saturates at `BREAK_CYCLES`.
  - Clears to 0 on the cycle `f[i]`=1.
  - `break_det[i]` = (count == BREAK_CYCLES), registered.
- Activity: `activity[i]` is set on any change of `f[i]` and cleared by `act_clr[i]`. If set and clear occur in the same cycle, set wins.
- Routing: per output `o`, config register {src[o], mode[o]}. `line_out[o]` is registered from `f[src[o]]` according to mode:
  - MODE_PASS=00: `f[src]`.
  - MODE_IDLE=01: constant 1.
  - MODE_BREAK=10: constant 0.
  - MODE_INV=11: ~`f[src]`.
- Config write: when `cfg_we`=1, `cfg_ch`<CHANNELS and `cfg_src`<CHANNELS, {src, mode} of `cfg_ch` update at that edge. Otherwise the write is dropped and `cfg_err` pulses high for the next cycle.
- Any input may fan out to several outputs. Unused outputs follow their own config.

## Timing
- Reset values:
  - `line_out` all 1.
  - `src[o]` = o, i.e. identity routing.
  - `mode` = MODE_PASS.
  - Synchroniser, sample and `f` registers all 1.
  - Break counters 0, `break_det` 0, `activity` 0, `cfg_err` 0.
- Latency: a level stable at `line_in[i]` from edge k appears on `line_out` at edge k+SYNC_STAGES+FILTER_LEN. With defaults that is 5 cycles, ±1 for sampling phase.
- Config: a write accepted at edge n affects `line_out` at edge n+1. Output never glitches between edges.
- Break: `break_det` rises BREAK_CYCLES+1 cycles after `f` falls and drops 1 cycle after `f` rises.
- `rst` asserted mid-operation: all state returns to reset values at that edge. `rst` beats a simultaneous `cfg_we` or `act_clr`.
- Counter wrap is not allowed; saturation holds indefinitely.

## Structure
- Package `serial_route_pkg`: `MODE_PASS/IDLE/BREAK/INV` constants, mode typedef, and the clog2 helper for CW and counter widths.
- Sub-module `line_conditioner`, one instance per input: synchroniser, filter, break counter and activity flag. Outputs `f`, `break_det` and `activity`.
- The top level holds the config registers, the crossbar mux and the output registers.

## Test plan
- Reset with CHANNELS=2 and `line_in`=2'b11, then drive `line_in[0]` low → `line_out[0]` goes 0 five cycles later and `line_out[1]` stays 1.
- Write `cfg_ch`=1, `cfg_src`=0, MODE_INV and toggle `line_in[0]` → `line_out[1]` = ~`line_out[0]`, updating one cycle after the write.
- Drive a 2-cycle low glitch on `line_in[1]` → `line_out[1]`, `activity[1]` and `break_det[1]` stay unchanged.
- Hold `line_in[0]` low for 1100 cycles with BREAK_CYCLES=1024 → `break_det[0]` rises and stays high, then falls 1 cycle after `f` returns high.
- Write `cfg_src`=2 with CHANNELS=2 → `cfg_err` pulses once and routing is unchanged. Assert `act_clr` on the same cycle as an edge → `activity` remains 1.
- Assert `rst` mid-break while MODE_BREAK is active → all outputs 1, identity routing restored, counters 0.
